// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: controller states and
// the bit-15-empty word convention used by both the receiver and the CPU view.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        WAIT  = 2'd2
    } rx_state_e;

    localparam logic [15:0] UART_EMPTY     = 16'h8000;
    localparam int          UART_EMPTY_BIT = 15;

    function automatic logic uart_word_empty(input logic [15:0] word);
        return word[UART_EMPTY_BIT];
    endfunction

    // Bits [14:8] of a valid word are never passed on.
    function automatic logic [15:0] uart_pack_byte(input logic [7:0] data);
        return {8'h00, data};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter; push is accepted when
// full only if a pop is taken on the same edge, pop is ignored when empty.
module sync_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = CNT_ONE[AW-1:0];
    localparam logic [AW:0]   FULL_CNT = CNT_ONE << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Drains the UART receiver word into a byte FIFO with a capture/clear/wait
// handshake and presents the FIFO head to the CPU in the same empty-bit format.
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rx_data,
    output logic        rx_clear,
    output logic [15:0] cpu_out,
    input  logic        cpu_pop,
    input  logic        cpu_clr_ovf,
    output logic [AW:0] count,
    output logic        overflow
);

    rx_state_e  state_q;
    logic       rx_clear_q;
    logic       overflow_q, overflow_d;
    logic       byte_valid, drop, push;
    logic       fifo_full, fifo_empty;
    logic [7:0] head;
    logic       unused_rx_bits;

    assign unused_rx_bits = ^rx_data[14:8];

    assign byte_valid = (state_q == IDLE) && !uart_word_empty(rx_data);
    // A full FIFO still accepts when the CPU frees a slot on the same edge.
    assign drop       = byte_valid && fifo_full && !cpu_pop;
    assign push       = byte_valid && !drop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (rx_data[7:0]),
        .pop_i   (cpu_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (cpu_clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_clear_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            rx_clear_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (byte_valid) begin
                        state_q    <= CLEAR;
                        rx_clear_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (uart_word_empty(rx_data)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Reset also clears the receiver so both sides restart empty.
    assign rx_clear = rx_clear_q | reset;
    assign overflow = overflow_q;
    assign cpu_out  = fifo_empty ? UART_EMPTY : uart_pack_byte(head);

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Bench for uart_rx_buffer_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the buffer.
module tb_uart_rx_buffer_ctrl;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [15:0] rx_data;
    logic        rx_clear;
    logic [15:0] cpu_out;
    logic        cpu_pop;
    logic        cpu_clr_ovf;
    logic [4:0]  count;
    logic        overflow;

    uart_rx_buffer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_clear    (rx_clear),
        .cpu_out     (cpu_out),
        .cpu_pop     (cpu_pop),
        .cpu_clr_ovf (cpu_clr_ovf),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: buffered bytes, sticky overflow, and when the controller may
    // accept again (idle once an empty word is seen two or more edges after
    // the capturing edge).
    logic [7:0] mq[$];
    bit         m_ovf     = 1'b0;
    bit         m_clr     = 1'b0;
    bit         m_busy    = 1'b0;
    int         m_cap_edge = 0;
    int         edge_no   = 0;

    task automatic model_edge();
        bit cap, drop, pop_eff;
        if (reset) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_clr  = 1'b0;
            m_busy = 1'b0;
        end else begin
            cap     = !m_busy && !rx_data[15];
            drop    = cap && (mq.size() == DEPTH) && !cpu_pop;
            pop_eff = cpu_pop && (mq.size() > 0);
            if (pop_eff) void'(mq.pop_front());
            if (cap && !drop) mq.push_back(rx_data[7:0]);
            if (drop) m_ovf = 1'b1;
            else if (cpu_clr_ovf) m_ovf = 1'b0;
            if (cap) begin
                m_busy     = 1'b1;
                m_cap_edge = edge_no;
            end else if (m_busy && edge_no >= m_cap_edge + 2 && rx_data[15]) begin
                m_busy = 1'b0;
            end
            m_clr = cap;
        end
        edge_no++;
    endtask

    bit          chk_en = 1'b0;
    logic [15:0] e_out;

    always @(negedge clk) begin
        if (chk_en) begin
            e_out = (mq.size() > 0) ? {8'h00, mq[0]} : 16'h8000;
            chk("cpu_out", {16'h0, cpu_out}, {16'h0, e_out});
            chk("count", {27'h0, count}, mq.size());
            chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
            chk("rx_clear", {31'h0, rx_clear}, {31'h0, m_clr | reset});
        end
    end

    // Receiver stand-in: empties the cycle after it sees rx_clear (plus an
    // optional extra stall), and a new byte only arrives after a gap.
    int rx_timer     = 0;
    int rx_extra     = 0;
    int rx_empty_cnt = 0;
    int clr_pulses   = 0;

    task automatic cyc();
        bit clr_seen;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        clr_seen = rx_clear;
        if (clr_seen && !reset) clr_pulses++;
        if (rx_timer > 0) begin
            rx_timer--;
            if (rx_timer == 0) rx_data = 16'h8000;
        end
        if (clr_seen) rx_timer = 1 + rx_extra;
        if (rx_data[15]) rx_empty_cnt++;
        else rx_empty_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while ((rx_empty_cnt < 2 || rx_timer != 0) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_ready_timeout: receiver still busy after %0d cycles, need empty", n);
        end
        rx_data = {8'h00, b};
    endtask

    task automatic handshake(input logic [7:0] b);
        send_byte(b);
        repeat (6) cyc();
    endtask

    task automatic pop1();
        cpu_pop = 1'b1;
        cyc();
        cpu_pop = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        rx_data     = 16'h8000;
        cpu_pop     = 1'b0;
        cpu_clr_ovf = 1'b0;
        chk_en      = 1'b1;
        repeat (2) cyc();
        chk("rst_rx_clear", {31'h0, rx_clear}, 32'h1);
        chk("rst_cpu_out", {16'h0, cpu_out}, 32'h8000);
        reset = 1'b0;
        repeat (3) cyc();
        chk("rst_count", {27'h0, count}, 32'h0);

        // single byte
        clr_pulses = 0;
        handshake(8'h41);
        chk("t1_clr_pulses", clr_pulses, 1);
        chk("t1_cpu_out", {16'h0, cpu_out}, 32'h0041);
        chk("t1_count", {27'h0, count}, 32'h1);
        pop1();
        chk("t1_pop_out", {16'h0, cpu_out}, 32'h8000);
        chk("t1_pop_count", {27'h0, count}, 32'h0);

        // burst to full, pointers already offset by one so they wrap
        for (int i = 0; i < 16; i++) handshake(8'(i));
        chk("t2_count", {27'h0, count}, 32'd16);
        chk("t2_model_size", mq.size(), 16);
        chk("t2_overflow", {31'h0, overflow}, 32'h0);

        // overflow: drop, clear, then clear racing a new drop
        clr_pulses = 0;
        handshake(8'hAA);
        chk("t3_overflow", {31'h0, overflow}, 32'h1);
        chk("t3_count", {27'h0, count}, 32'd16);
        chk("t3_clr_pulses", clr_pulses, 1);
        chk("t3_head", {16'h0, cpu_out}, 32'h0000);
        cpu_clr_ovf = 1'b1;
        cyc();
        cpu_clr_ovf = 1'b0;
        chk("t3_ovf_cleared", {31'h0, overflow}, 32'h0);
        send_byte(8'hBB);
        cpu_clr_ovf = 1'b1;
        cyc();
        cpu_clr_ovf = 1'b0;
        repeat (5) cyc();
        chk("t3_set_wins", {31'h0, overflow}, 32'h1);

        // full with simultaneous pop
        cpu_clr_ovf = 1'b1;
        cyc();
        cpu_clr_ovf = 1'b0;
        send_byte(8'h55);
        chk("t4_head0", {16'h0, cpu_out}, 32'h0000);
        cpu_pop = 1'b1;
        cyc();
        cpu_pop = 1'b0;
        repeat (5) cyc();
        chk("t4_count", {27'h0, count}, 32'd16);
        chk("t4_overflow", {31'h0, overflow}, 32'h0);
        for (int i = 1; i < 16; i++) begin
            chk("t4_order", {16'h0, cpu_out}, i);
            pop1();
        end
        chk("t4_last", {16'h0, cpu_out}, 32'h0055);
        pop1();
        chk("t4_drained", {16'h0, cpu_out}, 32'h8000);

        // pop on empty
        cpu_pop = 1'b1;
        repeat (2) cyc();
        cpu_pop = 1'b0;
        chk("t5_out", {16'h0, cpu_out}, 32'h8000);
        chk("t5_count", {27'h0, count}, 32'h0);
        handshake(8'h11);
        chk("t5_next", {16'h0, cpu_out}, 32'h0011);
        pop1();

        // reset while waiting for the receiver to empty
        handshake(8'h01);
        handshake(8'h02);
        rx_extra = 8;
        send_byte(8'h03);
        repeat (3) cyc();
        chk("t6_count_pre", {27'h0, count}, 32'h3);
        rx_extra = 0;
        reset = 1'b1;
        cyc();
        chk("t6_rx_clear", {31'h0, rx_clear}, 32'h1);
        cyc();
        reset = 1'b0;
        cyc();
        chk("t6_count", {27'h0, count}, 32'h0);
        chk("t6_out", {16'h0, cpu_out}, 32'h8000);
        handshake(8'h33);
        chk("t6_capture", {16'h0, cpu_out}, 32'h0033);
        chk("t6_count_post", {27'h0, count}, 32'h1);

        // randomized traffic with varying drain rate and stray upper bits
        for (int c = 0; c < 4000; c++) begin
            int p;
            p           = ((c / 500) % 2 == 1) ? 10 : 50;
            cpu_pop     = ($urandom % 100) < p;
            cpu_clr_ovf = ($urandom % 100) < 4;
            reset       = ($urandom % 200) == 0;
            rx_extra    = $urandom_range(0, 2);
            if (!reset && rx_empty_cnt >= 2 && rx_timer == 0 && ($urandom % 100) < 40)
                rx_data = {1'b0, 7'($urandom), 8'($urandom)};
            cyc();
        end
        cpu_pop     = 1'b0;
        cpu_clr_ovf = 1'b0;
        reset       = 1'b0;
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
